// File: rtl/bridge_bus_scheduler_if.sv
// Bundle of the two requester ports and the master_port command bus.
// Handshake: rX_valid is held with its fields until a 1-cycle rX_ready accept; m_dvalid is a 1-cycle start.
interface bridge_bus_scheduler_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic                  r0_valid, r0_ready, r0_mode, r0_done, r0_err;
  logic [ADDR_WIDTH-1:0] r0_addr;
  logic [DATA_WIDTH-1:0] r0_wdata, r0_rdata;
  logic                  r1_valid, r1_ready, r1_mode, r1_done, r1_err;
  logic [ADDR_WIDTH-1:0] r1_addr;
  logic [DATA_WIDTH-1:0] r1_wdata, r1_rdata;
  logic                  m_dvalid, m_dready, m_dmode;
  logic [ADDR_WIDTH-1:0] m_daddr;
  logic [DATA_WIDTH-1:0] m_dwdata, m_drdata;
  logic                  busy, owner;

  modport master (
    input  r0_valid, r0_mode, r0_addr, r0_wdata,
    output r0_ready, r0_done, r0_rdata, r0_err,
    input  r1_valid, r1_mode, r1_addr, r1_wdata,
    output r1_ready, r1_done, r1_rdata, r1_err,
    output m_dvalid, m_dmode, m_daddr, m_dwdata,
    input  m_dready, m_drdata,
    output busy, owner
  );

  modport slave (
    output r0_valid, r0_mode, r0_addr, r0_wdata,
    input  r0_ready, r0_done, r0_rdata, r0_err,
    output r1_valid, r1_mode, r1_addr, r1_wdata,
    input  r1_ready, r1_done, r1_rdata, r1_err,
    input  m_dvalid, m_dmode, m_daddr, m_dwdata,
    output m_dready, m_drdata,
    input  busy, owner
  );
endinterface

// File: rtl/bridge_bus_scheduler.sv
// Round-robin scheduler sharing one master_port between two requesters,
// sequencing issue / wait-busy / wait-done with a per-transaction watchdog.
module bridge_bus_scheduler #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TO_CNT_WIDTH   = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  bridge_bus_scheduler_if.master bus,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_RESP      = 3'd4,
    S_TOUT      = 3'd5
  } state_t;

  state_t                  state, state_nx;
  logic                    rr, owner_q, mode_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q, rdata0_q, rdata1_q;
  logic [TO_CNT_WIDTH-1:0] wd;
  logic                    grant_any, grant_id, wd_expired, zero_wait, capture;

  // rst gating keeps the ready pulses low while reset is held
  assign grant_any  = (state == S_IDLE) && bus.m_dready && (bus.r0_valid || bus.r1_valid) && !rst;
  assign grant_id   = (bus.r0_valid && bus.r1_valid) ? rr : bus.r1_valid;
  assign wd_expired = (wd == TO_CNT_WIDTH'(TIMEOUT_CYCLES - 1));
  assign zero_wait  = (state == S_WAIT_BUSY) && bus.m_dready && (wd == TO_CNT_WIDTH'(1));
  assign capture    = !mode_q && (zero_wait || ((state == S_WAIT_DONE) && bus.m_dready));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:      if (grant_any) state_nx = S_ISSUE;
      S_ISSUE:     state_nx = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (!bus.m_dready) state_nx = S_WAIT_DONE;
        else if (zero_wait) state_nx = S_RESP;
      end
      S_WAIT_DONE: begin
        if (bus.m_dready)    state_nx = S_RESP;
        else if (wd_expired) state_nx = S_TOUT;
      end
      S_RESP, S_TOUT: state_nx = S_IDLE;
      default:        state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr       <= 1'b0;
      owner_q  <= 1'b0;
      mode_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wd       <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (grant_any) begin
        owner_q <= grant_id;
        mode_q  <= grant_id ? bus.r1_mode  : bus.r0_mode;
        addr_q  <= grant_id ? bus.r1_addr  : bus.r0_addr;
        wdata_q <= grant_id ? bus.r1_wdata : bus.r0_wdata;
      end
      if (state == S_ISSUE) wd <= '0;
      else if (state == S_WAIT_BUSY || state == S_WAIT_DONE) wd <= wd + 1'b1;
      if (capture) begin
        if (owner_q) rdata1_q <= bus.m_drdata;
        else         rdata0_q <= bus.m_drdata;
      end
      // Completion or abort hands priority to the other requester
      if (state == S_RESP || state == S_TOUT) rr <= ~owner_q;
    end
  end

  always_comb begin
    bus.r0_ready = grant_any && !grant_id;
    bus.r1_ready = grant_any && grant_id;
    bus.m_dvalid = (state == S_ISSUE);
    bus.r0_done  = (state == S_RESP || state == S_TOUT) && !owner_q;
    bus.r1_done  = (state == S_RESP || state == S_TOUT) && owner_q;
    bus.r0_err   = (state == S_TOUT) && !owner_q;
    bus.r1_err   = (state == S_TOUT) && owner_q;
    bus.busy     = (state != S_IDLE);
    bus.owner    = owner_q;
    bus.m_dmode  = mode_q;
    bus.m_daddr  = addr_q;
    bus.m_dwdata = wdata_q;
    bus.r0_rdata = rdata0_q;
    bus.r1_rdata = rdata1_q;
    dbg_state    = state;
  end

endmodule

// File: tb/tb_bridge_bus_scheduler.sv
// Randomized scoreboard bench for bridge_bus_scheduler with a transaction-level
// reference model of arbitration, latency, timeout and read-data return.
module tb_bridge_bus_scheduler;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int TO = 16;
  localparam int TW = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] dbg_state;
  int         cyc = 0;

  bridge_bus_scheduler_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  bridge_bus_scheduler #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO), .TO_CNT_WIDTH(TW)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic          port;
    logic          mode;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            gcyc;
  } txn_t;
  typedef struct packed {
    logic          port;
    logic          err;
    logic          upd;
    logic [DW-1:0] data;
    int            dcyc;
  } done_t;
  // kind: 0 = answers after lat busy cycles, 1 = zero-wait, 2 = never answers in time
  typedef struct packed {
    logic [1:0]    kind;
    int            lat;
    logic [DW-1:0] data;
  } plan_t;

  txn_t          exp_txn_q[$];
  done_t         exp_done_q[$];
  plan_t         plan_q[$];
  int            grant_log[$];
  logic          model_rr = 1'b0;
  logic [DW-1:0] model_rdata [2];
  int            done_count = 0;
  int            errors = 0;
  int            checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- grant monitor ----------------
  always @(negedge clk) begin
    if (!rst && (bus.r0_ready || bus.r1_ready)) begin
      logic p;
      txn_t t;
      p = bus.r1_ready;
      chk("single_ready", 32'(bus.r0_ready & bus.r1_ready), 0);
      chk("grant_needs_dready", 32'(bus.m_dready), 1);
      if (bus.r0_valid && bus.r1_valid) chk("grant_rr", 32'(p), 32'(model_rr));
      else chk("grant_valid", 32'(p ? bus.r1_valid : bus.r0_valid), 1);
      t.port  = p;
      t.mode  = p ? bus.r1_mode  : bus.r0_mode;
      t.addr  = p ? bus.r1_addr  : bus.r0_addr;
      t.wdata = p ? bus.r1_wdata : bus.r0_wdata;
      t.gcyc  = cyc;
      exp_txn_q.push_back(t);
      grant_log.push_back(int'(p));
    end
  end

  // ---------------- master_port responder + issue checker ----------------
  initial begin
    bus.m_dready = 1'b1;
    bus.m_drdata = '0;
    forever begin
      @(negedge clk);
      if (!rst && bus.m_dvalid) begin
        txn_t  t;
        plan_t pl;
        done_t d;
        int    t0;
        int    r;
        t0 = cyc;
        if (exp_txn_q.size() == 0) begin
          chk("dvalid_without_grant", 1, 0);
          t = '0;
        end else begin
          t = exp_txn_q.pop_front();
          chk("issue_mode", 32'(bus.m_dmode), 32'(t.mode));
          chk("issue_addr", 32'(bus.m_daddr), 32'(t.addr));
          chk("issue_wdata", 32'(bus.m_dwdata), 32'(t.wdata));
          chk("issue_latency", 32'(t0), 32'(t.gcyc + 1));
          chk("busy_on_issue", 32'(bus.busy), 1);
          chk("owner_on_issue", 32'(bus.owner), 32'(t.port));
        end
        if (plan_q.size() != 0) pl = plan_q.pop_front();
        else begin
          r = $urandom_range(0, 9);
          pl.kind = (r == 0) ? 2'd2 : (r < 3) ? 2'd1 : 2'd0;
          pl.lat  = (pl.kind == 2'd2) ? TO + $urandom_range(2, 6) : $urandom_range(2, 10);
          pl.data = DW'($urandom);
        end
        d.port = t.port;
        d.err  = (pl.kind == 2'd2);
        d.upd  = (pl.kind != 2'd2) && !t.mode;
        d.data = pl.data;
        d.dcyc = (pl.kind == 2'd1) ? t0 + 3 : (pl.kind == 2'd2) ? t0 + TO + 1 : t0 + pl.lat + 1;
        exp_done_q.push_back(d);
        if (pl.kind == 2'd1) bus.m_drdata = pl.data;
        else begin
          bus.m_dready = 1'b0;
          repeat (pl.lat) @(posedge clk);
          #2;
          bus.m_drdata = pl.data;
          bus.m_dready = 1'b1;
        end
      end
    end
  end

  // ---------------- completion monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      logic [1:0] dn, er;
      logic       p;
      done_t      e;
      dn = {bus.r1_done, bus.r0_done};
      er = {bus.r1_err, bus.r0_err};
      if ((er & ~dn) != 2'b00) chk("err_without_done", 32'(er & ~dn), 0);
      if (dn != 2'b00) begin
        chk("single_done", 32'(dn == 2'b11), 0);
        p = dn[1];
        if (exp_done_q.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          e = exp_done_q.pop_front();
          chk("done_port", 32'(p), 32'(e.port));
          chk("done_err", 32'(er[p]), 32'(e.err));
          chk("done_cycle", 32'(cyc), 32'(e.dcyc));
          chk("done_owner", 32'(bus.owner), 32'(e.port));
          if (e.upd) model_rdata[e.port] = e.data;
          chk("rdata0", 32'(bus.r0_rdata), 32'(model_rdata[0]));
          chk("rdata1", 32'(bus.r1_rdata), 32'(model_rdata[1]));
          model_rr = ~e.port;
          done_count++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_req(input logic p, input logic mode, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata);
    int   n;
    logic got;
    n = 0;
    got = 1'b0;
    if (p) begin
      bus.r1_mode = mode; bus.r1_addr = addr; bus.r1_wdata = wdata; bus.r1_valid = 1'b1;
    end else begin
      bus.r0_mode = mode; bus.r0_addr = addr; bus.r0_wdata = wdata; bus.r0_valid = 1'b1;
    end
    while (!got && n < 400) begin
      @(negedge clk);
      n++;
      got = p ? bus.r1_ready : bus.r0_ready;
    end
    if (!got) chk("ready_wait", 0, 1);
    @(posedge clk);
    #1;
    if (p) bus.r1_valid = 1'b0;
    else   bus.r0_valid = 1'b0;
  endtask

  task automatic wait_quiet();
    int   n;
    logic quiet;
    n = 0;
    quiet = 1'b0;
    while (!quiet && n < 600) begin
      @(negedge clk);
      n++;
      quiet = (exp_txn_q.size() == 0) && (exp_done_q.size() == 0) && bus.m_dready;
    end
    if (!quiet) chk("quiet_wait", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    int n;
    rst = 1'b1;
    #1;
    chk("rst_async_ctrl", 32'({bus.busy, bus.r0_done, bus.r1_done, bus.m_dvalid,
                               bus.r0_ready, bus.r1_ready, bus.r0_err, bus.r1_err}), 0);
    n = 0;
    while (!bus.m_dready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.m_dready) chk("rst_dready_wait", 0, 1);
    exp_txn_q.delete();
    exp_done_q.delete();
    plan_q.delete();
    grant_log.delete();
    model_rr = 1'b0;
    model_rdata[0] = '0;
    model_rdata[1] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_owner_mode", 32'({bus.owner, bus.m_dmode}), 0);
    chk("rst_daddr", 32'(bus.m_daddr), 0);
    chk("rst_dwdata", 32'(bus.m_dwdata), 0);
    chk("rst_rdata", 32'({bus.r0_rdata, bus.r1_rdata}), 0);
    chk("rst_state", 32'(dbg_state), 0);
    rst = 1'b0;
  endtask

  task automatic random_stream(input logic p, input int count);
    int g;
    for (int i = 0; i < count; i++) begin
      g = $urandom_range(0, 3);
      if (g > 0) begin
        repeat (g) @(posedge clk);
        #1;
      end
      drive_req(p, 1'($urandom), AW'($urandom), DW'($urandom));
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int d0;
    bus.r0_valid = 1'b0; bus.r0_mode = 1'b0; bus.r0_addr = '0; bus.r0_wdata = '0;
    bus.r1_valid = 1'b0; bus.r1_mode = 1'b0; bus.r1_addr = '0; bus.r1_wdata = '0;
    model_rdata[0] = '0;
    model_rdata[1] = '0;
    repeat (2) @(posedge clk);
    do_reset();

    // Single read, ten busy cycles
    plan_q.push_back('{2'd0, 10, 8'hA5});
    drive_req(1'b0, 1'b0, 16'h1234, 8'h00);
    wait_quiet();
    chk("single_read_rdata", 32'(bus.r0_rdata), 32'h0000_00A5);
    chk("single_read_grants", 32'(grant_log.size()), 1);

    // Simultaneous writes from reset, twice
    do_reset();
    for (int k = 0; k < 2; k++) begin
      fork
        drive_req(1'b0, 1'b1, 16'h0100, 8'h11);
        drive_req(1'b1, 1'b1, 16'h0200, 8'h22);
      join
      wait_quiet();
    end
    chk("simul_grants", 32'(grant_log.size()), 4);
    for (int i = 0; i < grant_log.size(); i++) chk("simul_order", 32'(grant_log[i]), 32'(i % 2));

    // Fairness: both held valid for six transactions
    grant_log.delete();
    d0 = done_count;
    fork
      for (int i = 0; i < 3; i++) drive_req(1'b0, 1'($urandom), AW'($urandom), DW'($urandom));
      for (int j = 0; j < 3; j++) drive_req(1'b1, 1'($urandom), AW'($urandom), DW'($urandom));
    join
    wait_quiet();
    chk("fair_done_count", 32'(done_count - d0), 6);
    for (int i = 0; i < grant_log.size(); i++) chk("fair_order", 32'(grant_log[i]), 32'(i % 2));

    // Timeout on r1 with r0 pending behind a stuck port
    plan_q.push_back('{2'd2, TO + 4, 8'h5A});
    plan_q.push_back('{2'd0, 3, 8'h3C});
    fork
      drive_req(1'b1, 1'b0, 16'h0300, 8'h00);
      begin
        repeat (4) @(posedge clk);
        #1;
        drive_req(1'b0, 1'b0, 16'h0400, 8'h00);
      end
    join
    wait_quiet();

    // Zero-wait port
    plan_q.push_back('{2'd1, 0, 8'hC3});
    drive_req(1'b1, 1'b0, 16'h0500, 8'h00);
    wait_quiet();

    // Random traffic
    fork
      random_stream(1'b0, $urandom_range(6, 12));
      random_stream(1'b1, $urandom_range(6, 12));
    join
    wait_quiet();

    // Reset while in WAIT_DONE, then both requesters together
    plan_q.push_back('{2'd0, 12, 8'h77});
    drive_req(1'b0, 1'b0, 16'h0600, 8'h00);
    repeat (5) @(posedge clk);
    #2;
    do_reset();
    fork
      drive_req(1'b0, 1'b1, 16'h0700, 8'h01);
      drive_req(1'b1, 1'b1, 16'h0800, 8'h02);
    join
    wait_quiet();
    chk("post_reset_first_grant", 32'(grant_log[0]), 0);
    chk("queues_drained", 32'(exp_txn_q.size() + exp_done_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule
